uart_tx_feeder: RTL
===================

# uart_tx_feeder

Byte buffer and launch sequencer that sits directly upstream of the UART transmitter. It accepts bytes from producer logic through a valid/ready write port and stores them in a DEPTH-entry FIFO. It then issues one-cycle `tx_start` pulses with stable `tx_data` to the transmitter, sending exactly one byte per transmitter frame. It also flags dropped writes and reports fill level for debug.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth = 2^DEPTH_LOG2 entries (16).
- `GAP_CYCLES`, 0: extra idle clocks inserted after the transmitter drops `tx_busy` before the next launch; range 0–255.

- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_data`  in  8  byte to enqueue.
- `wr_valid`  in  1  enqueue request.
- `wr_ready`  out  1  FIFO not full; combinational from the registered count.
- `fifo_count`  out  DEPTH_LOG2+1  number of stored entries.
- `overflow`  out  1  sticky flag: a write was attempted while full.
- `ovf_clr`  in  1  clears `overflow`.
- `tx_data`  out  8  byte to the transmitter; stable from launch until the next launch.
- `tx_start`  out  1  one-cycle launch pulse to the transmitter.
- `tx_busy`  in  1  transmitter busy; rises the cycle after an accepted `tx_start`.
- `idle`  out  1  FIFO empty and FSM in IDLE.

## Operation
- FIFO: circular buffer with pointers DEPTH_LOG2 bits wide that wrap naturally, plus a separate count register.
- Write is accepted when `wr_valid && wr_ready`.
- `wr_valid` while full: data dropped, `overflow` set.
  - A pop in the same cycle does not make room.
- Simultaneous accepted write and pop: count unchanged, both pointers advance.
  - With count 0, a write is not poppable until the next cycle (no fall-through).
- `overflow`: set has priority over `ovf_clr` in the same cycle.
- FSM states:
  - IDLE: if `fifo_count != 0` and `tx_busy == 0`, pop the head into `tx_data`, assert `tx_start` next cycle, go to LAUNCH.
  - LAUNCH: `tx_start` high for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: on `tx_busy == 1`, go to WAIT_DONE. If `tx_busy` stays low 4 cycles, go to IDLE; the byte counts as sent, no retry.
  - WAIT_DONE: on `tx_busy == 0`, go to GAP if `GAP_CYCLES > 0`, else go to IDLE.
  - GAP: count `GAP_CYCLES` clocks, then go to IDLE.
- Illegal state encoding: go to IDLE.

## Timing
- Reset values:
  - `tx_start` 0, `tx_data` 0x00, `fifo_count` 0, `overflow` 0.
  - `wr_ready` 1, `idle` 1; FSM in IDLE, pointers 0.
- Write accepted at edge N: `fifo_count` updates after edge N.
- With the FSM in IDLE and `tx_busy` low, launch occurs the cycle after the count becomes nonzero.
  - Write-to-`tx_start` latency is 2 clocks: the write edge plus the IDLE pop edge.
- `tx_data` is valid in the same cycle as `tx_start`.
- Back-to-back launches are spaced by at least one full frame (434 × 10 clocks + transmitter cleanup) plus `GAP_CYCLES`.
- `tx_start` is never asserted while `tx_busy` is high.
- Reset mid-frame clears the FIFO and FSM immediately; `tx_start` goes low asynchronously. The transmitter shares `rst_n`.

## Test plan
- Single byte: write 0x55 with the transmitter model idle.
  - Expect `tx_start` 2 clocks later with `tx_data` = 0x55, one pulse only.
  - `idle` returns to 1 after `tx_busy` falls.
- Burst of 20 writes (0x00–0x13) on consecutive cycles with the transmitter busy.
  - Expect 16 accepted, `wr_ready` low at count 16, `overflow` set.
  - Serial output is 0x00–0x0F in order; 0x10–0x13 are lost.
- Count 1 plus a simultaneous write and pop: `fifo_count` stays 1 and the second byte launches after the first frame.
  - Run past pointer wrap (40 bytes total) with no corruption.
- `GAP_CYCLES` = 3: measure exactly 3 idle clocks between `tx_busy` falling and the pop decision of the next byte.
- Busy never asserted (model ignores start): FSM returns to IDLE after 4 cycles and launches the next byte. No hang.
- Reset asserted mid-frame with 5 bytes queued:
  - Outputs return to reset values, `fifo_count` 0.
  - After release, a new byte 0xA5 transmits correctly.
- `overflow` set, then `ovf_clr` pulsed: flag clears.
  - `ovf_clr` pulsed in the same cycle as an overflow write: flag stays 1.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: accepts bytes on a valid/ready port and
// launches them one per frame with a single-cycle tx_start pulse and held tx_data.
`timescale 1ns/1ps
module uart_tx_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic                  idle
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO   = {(DEPTH_LOG2 + 1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1'b1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1'b1);
    localparam logic [7:0]            GAP_LAST   = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [1:0]            WAIT_LAST  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_start_q, tx_start_d;
    logic [1:0]              wait_cnt_q, wait_cnt_d;
    logic [7:0]              gap_cnt_q, gap_cnt_d;

    logic                    full_s;
    logic                    wr_accept_s;
    logic                    pop_s;

    // FIFO bookkeeping: a pop in the same cycle never frees room for a write while full
    always_comb begin
        full_s      = (count_q == CNT_FULL);
        wr_accept_s = wr_valid && !full_s;

        if (wr_accept_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_accept_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (wr_valid && full_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Launch sequencer: pop in IDLE, pulse in LAUNCH, then follow the transmitter's busy
    always_comb begin
        state_d    = state_q;
        pop_s      = 1'b0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        wait_cnt_d = wait_cnt_q;
        gap_cnt_d  = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if ((count_q != CNT_ZERO) && !tx_busy) begin
                    pop_s      = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                    tx_start_d = 1'b1;
                    state_d    = ST_LAUNCH;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                wait_cnt_d = 2'd0;
                state_d    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // A transmitter that never answers must not stall the queue
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (GAP_CYCLES > 0) begin
                        gap_cnt_d = 8'd0;
                        state_d   = ST_GAP;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= {DEPTH_LOG2{1'b0}};
            rd_ptr_q   <= {DEPTH_LOG2{1'b0}};
            count_q    <= CNT_ZERO;
            ovf_q      <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            wait_cnt_q <= 2'd0;
            gap_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            wait_cnt_q <= wait_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (wr_accept_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign wr_ready   = !full_s;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign idle       = (count_q == CNT_ZERO) && (state_q == ST_IDLE);

endmodule
